uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-limited sharing of one uart_tx between two first-word-fall-through byte sources.
// Each byte is popped and started in a single LOAD cycle, then uart_tx busy is tracked until it finishes.
module uart_tx_arbiter #(
    parameter int BURST = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       src0_data,
    input  logic             src0_valid,
    output logic             src0_pop,
    input  logic [7:0]       src1_data,
    input  logic             src1_valid,
    output logic             src1_pop,
    input  logic             enable,
    output logic [7:0]       txdata,
    output logic             tx_start,
    input  logic             tx_busy,
    output logic [1:0]       grant,
    output logic [CNT_W-1:0] sent0,
    output logic [CNT_W-1:0] sent1
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [7:0]       BURST_MAX = 8'(BURST);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [1:0]       ACK_LAST  = 2'd3;

    state_t     state_r;
    logic [7:0] burst_cnt_r;
    logic [1:0] ack_cnt_r;
    logic       last_owner_r;

    logic       pick_s;
    logic       sel_s;
    logic       sel_valid_s;
    logic [7:0] sel_data_s;
    logic       issue_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == {CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

    // Source selection and the decision to start a byte on the next edge
    always_comb begin
        pick_s      = 1'b0;
        sel_s       = 1'b0;
        sel_valid_s = 1'b0;
        sel_data_s  = 8'h00;
        issue_s     = 1'b0;
        if (src0_valid && src1_valid) begin
            pick_s = ~last_owner_r;
        end else if (src1_valid) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
        // Outside IDLE the owner is frozen in grant
        if (state_r == IDLE) begin
            sel_s = pick_s;
        end else begin
            sel_s = grant[1];
        end
        if (sel_s) begin
            sel_valid_s = src1_valid;
            sel_data_s  = src1_data;
        end else begin
            sel_valid_s = src0_valid;
            sel_data_s  = src0_data;
        end
        case (state_r)
            IDLE:      issue_s = enable && !tx_busy && sel_valid_s;
            WAIT_DONE: issue_s = enable && !tx_busy && sel_valid_s && (burst_cnt_r < BURST_MAX);
            default:   issue_s = 1'b0;
        endcase
    end

    // Arbitration FSM; every output is registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            burst_cnt_r  <= 8'd0;
            ack_cnt_r    <= 2'd0;
            last_owner_r <= 1'b1;
            txdata       <= 8'h00;
            tx_start     <= 1'b0;
            src0_pop     <= 1'b0;
            src1_pop     <= 1'b0;
            grant        <= 2'b00;
            sent0        <= {CNT_W{1'b0}};
            sent1        <= {CNT_W{1'b0}};
        end else begin
            tx_start <= 1'b0;
            src0_pop <= 1'b0;
            src1_pop <= 1'b0;
            if (issue_s) begin
                // Entering LOAD: start and pop become visible together in that cycle
                state_r  <= LOAD;
                txdata   <= sel_data_s;
                tx_start <= 1'b1;
                grant    <= sel_s ? 2'b10 : 2'b01;
                if (sel_s) begin
                    src1_pop <= 1'b1;
                    sent1    <= sat_inc(sent1);
                end else begin
                    src0_pop <= 1'b1;
                    sent0    <= sat_inc(sent0);
                end
                burst_cnt_r <= (state_r == IDLE) ? 8'd1 : burst_cnt_r + 8'd1;
            end else begin
                case (state_r)
                    IDLE: begin
                        grant <= 2'b00;
                    end
                    LOAD: begin
                        state_r   <= WAIT_ACK;
                        ack_cnt_r <= 2'd0;
                    end
                    WAIT_ACK: begin
                        if (tx_busy || (ack_cnt_r == ACK_LAST)) begin
                            state_r <= WAIT_DONE;
                        end else begin
                            ack_cnt_r <= ack_cnt_r + 2'd1;
                        end
                    end
                    WAIT_DONE: begin
                        if (!tx_busy) begin
                            last_owner_r <= grant[1];
                            grant        <= 2'b00;
                            state_r      <= IDLE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed table, hand-written corner sequences and randomized
// source/uart timing checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int BURST = 4;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    typedef struct {
        logic [7:0] data;
        logic       own;
    } exp_t;

    typedef struct {
        int          n0;
        int          n1;
        logic [31:0] owners;
        int          s0;
        int          s1;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       src0_data;
    logic             src0_valid;
    logic             src0_pop;
    logic [7:0]       src1_data;
    logic             src1_valid;
    logic             src1_pop;
    logic             enable;
    logic [7:0]       txdata;
    logic             tx_start;
    logic             tx_busy;
    logic [1:0]       grant;
    logic [CNT_W-1:0] sent0;
    logic [CNT_W-1:0] sent1;

    exp_t       exp_q[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rise_cnt = 0;
    int hold_cnt = 0;
    bit rnd_uart = 1'b0;
    bit never_ack = 1'b0;
    int rd_fix = 1;
    int dur_fix = 3;

    uart_tx_arbiter #(.BURST(BURST), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .src0_data(src0_data), .src0_valid(src0_valid), .src0_pop(src0_pop),
        .src1_data(src1_data), .src1_valid(src1_valid), .src1_pop(src1_pop),
        .enable(enable), .txdata(txdata), .tx_start(tx_start), .tx_busy(tx_busy),
        .grant(grant), .sent0(sent0), .sent1(sent1)
    );

    // 100 MHz-style bench clock; only relative timing matters
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [7:0] data, input logic own);
        exp_t e;
        e.data = data;
        e.own  = own;
        exp_q.push_back(e);
    endtask

    // One cycle: observe at negedge, then model the FIFOs and uart_tx, then drive inputs
    task automatic tick();
        logic       busy_pre;
        exp_t       e;
        logic [1:0] eg;
        bit         nvr;
        @(negedge clk);
        cyc++;
        busy_pre = tx_busy;
        if (tx_start || src0_pop || src1_pop) begin
            chk("start_with_pop", int'(tx_start), 1);
            chk("start_while_busy", int'(busy_pre), 0);
            chk("exp_pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                eg = e.own ? 2'b10 : 2'b01;
                chk("txdata", int'(txdata), int'(e.data));
                chk("grant", int'(grant), int'(eg));
                chk("pops", int'({src1_pop, src0_pop}), int'(eg));
            end
            if (src0_pop) chk("pop0_valid", int'(src0_valid), 1);
            if (src1_pop) chk("pop1_valid", int'(src1_valid), 1);
        end
        if (src0_pop && q0.size() > 0) q0.delete(0);
        if (src1_pop && q1.size() > 0) q1.delete(0);
        if (rst) begin
            rise_cnt = 0;
            hold_cnt = 0;
            tx_busy  = 1'b0;
        end else begin
            if (rise_cnt > 0) begin
                rise_cnt--;
                if (rise_cnt == 0) tx_busy = 1'b1;
            end else if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) tx_busy = 1'b0;
            end
            if (tx_start && !busy_pre) begin
                nvr = rnd_uart ? ($urandom_range(0, 7) == 0) : never_ack;
                if (!nvr) begin
                    rise_cnt = rnd_uart ? int'($urandom_range(1, 2)) : rd_fix;
                    hold_cnt = rnd_uart ? int'($urandom_range(1, 6)) : dur_fix;
                end
            end
        end
        src0_valid = (q0.size() > 0);
        src1_valid = (q1.size() > 0);
        if (q0.size() > 0) src0_data = q0[0]; else src0_data = 8'h00;
        if (q1.size() > 0) src1_data = q1[0]; else src1_data = 8'h00;
    endtask

    task automatic apply_reset();
        rst    = 1'b1;
        enable = 1'b0;
        q0.delete();
        q1.delete();
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_txdata"}, int'(txdata), 0);
        chk({tag, "_tx_start"}, int'(tx_start), 0);
        chk({tag, "_pops"}, int'({src1_pop, src0_pop}), 0);
        chk({tag, "_grant"}, int'(grant), 0);
        chk({tag, "_sent0"}, int'(sent0), 0);
        chk({tag, "_sent1"}, int'(sent1), 0);
    endtask

    task automatic wait_start(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (tx_start) begin
                n = i;
                break;
            end
        end
        chk("start_seen", int'(n > 0), 1);
    endtask

    task automatic wait_busy(input logic val, input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (tx_busy == val) begin
                seen = 1'b1;
                break;
            end
        end
        chk("busy_level_seen", int'(seen), 1);
    endtask

    task automatic drain(input int max);
        bit done = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (exp_q.size() == 0 && grant == 2'b00 && !tx_busy) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_done", int'(done), 1);
        repeat (3) tick();
    endtask

    // Transaction-level arbitration: whole bursts decided from queue occupancy
    task automatic ref_model(input int n0, input int n1);
        int i0 = 0;
        int i1 = 0;
        int k;
        bit last = 1'b1;
        bit own;
        while (i0 < n0 || i1 < n1) begin
            if (i0 < n0 && i1 < n1) own = !last;
            else own = (i1 < n1);
            k = 0;
            while (k < BURST && (own ? (i1 < n1) : (i0 < n0))) begin
                if (own) begin
                    push_exp(q1[i1], 1'b1);
                    i1++;
                end else begin
                    push_exp(q0[i0], 1'b0);
                    i0++;
                end
                k++;
            end
            last = own;
        end
    endtask

    initial begin
        vec_t tbl[8];
        int   n;
        int   j0;
        int   j1;
        int   n0;
        int   n1;
        // owners: bit i is the expected source of the i-th byte sent (BURST=4, last_owner starts at 1)
        tbl[0] = '{n0: 3,  n1: 0,  owners: 32'h0000_0000, s0: 3,  s1: 0};
        tbl[1] = '{n0: 0,  n1: 2,  owners: 32'h0000_0003, s0: 0,  s1: 2};
        tbl[2] = '{n0: 6,  n1: 6,  owners: 32'h0000_0CF0, s0: 6,  s1: 6};
        tbl[3] = '{n0: 1,  n1: 5,  owners: 32'h0000_003E, s0: 1,  s1: 5};
        tbl[4] = '{n0: 9,  n1: 0,  owners: 32'h0000_0000, s0: 9,  s1: 0};
        tbl[5] = '{n0: 10, n1: 10, owners: 32'h000C_F0F0, s0: 10, s1: 10};
        tbl[6] = '{n0: 12, n1: 9,  owners: 32'h0010_F0F0, s0: 12, s1: 9};
        tbl[7] = '{n0: 17, n1: 0,  owners: 32'h0000_0000, s0: 15, s1: 0};

        rst = 1'b1; enable = 1'b0; tx_busy = 1'b0;
        src0_valid = 1'b0; src1_valid = 1'b0; src0_data = 8'h00; src1_data = 8'h00;
        apply_reset();
        check_reset_outputs("reset");

        // Single source, three bytes: start latency and back-to-back restart after busy falls
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(8'(8'h41 + i));
            push_exp(8'(8'h41 + i), 1'b0);
        end
        enable = 1'b1;
        wait_start(5, n);
        chk("first_latency", n, 2);
        wait_busy(1'b1, 10);
        wait_busy(1'b0, 20);
        tick();
        chk("b2b_start", int'(tx_start), 1);
        drain(400);
        chk("one_src_sent0", int'(sent0), 3);
        chk("one_src_sent1", int'(sent1), 0);

        // Burst end with the other source waiting: exactly one idle cycle with grant 00
        apply_reset();
        for (int i = 0; i < 5; i++) q0.push_back(8'(8'hA0 + i));
        q1.push_back(8'hB0);
        for (int i = 0; i < 4; i++) push_exp(8'(8'hA0 + i), 1'b0);
        push_exp(8'hB0, 1'b1);
        push_exp(8'hA4, 1'b0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) wait_start(40, n);
        wait_busy(1'b1, 10);
        wait_busy(1'b0, 20);
        tick();
        chk("gap_grant", int'(grant), 0);
        chk("gap_start", int'(tx_start), 0);
        tick();
        chk("rearb_start", int'(tx_start), 1);
        drain(400);

        // enable dropped during the second byte: it completes, then nothing more until re-enabled
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            q0.push_back(8'(8'hA0 + i));
            q1.push_back(8'(8'hB0 + i));
        end
        push_exp(8'hA0, 1'b0);
        push_exp(8'hA1, 1'b0);
        enable = 1'b1;
        wait_start(5, n);
        wait_start(40, n);
        enable = 1'b0;
        wait_busy(1'b1, 10);
        wait_busy(1'b0, 20);
        repeat (8) tick();
        chk("en_grant", int'(grant), 0);
        chk("en_sent0", int'(sent0), 2);
        chk("en_q0_left", q0.size(), 3);
        push_exp(8'hB0, 1'b1);
        enable = 1'b1;
        wait_start(5, n);

        // Reset pulse while waiting for the byte to finish
        apply_reset();
        for (int i = 0; i < 3; i++) q0.push_back(8'(8'hA0 + i));
        push_exp(8'hA0, 1'b0);
        enable = 1'b1;
        wait_start(5, n);
        wait_busy(1'b1, 10);
        tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        chk("midrst_no_extra_pop", q0.size(), 2);
        rst = 1'b0;
        push_exp(8'hA1, 1'b0);
        push_exp(8'hA2, 1'b0);
        drain(400);
        chk("midrst_sent0", int'(sent0), 2);

        // uart_tx never acknowledges: 1 LOAD + 4 WAIT_ACK + 1 WAIT_DONE before the next start
        apply_reset();
        never_ack = 1'b1;
        q0.push_back(8'h55);
        q0.push_back(8'hAA);
        push_exp(8'h55, 1'b0);
        push_exp(8'hAA, 1'b0);
        enable = 1'b1;
        wait_start(5, n);
        wait_start(20, n);
        chk("timeout_gap", n, 6);
        drain(100);
        never_ack = 1'b0;

        // Directed table
        for (int v = 0; v < 8; v++) begin
            apply_reset();
            for (int i = 0; i < tbl[v].n0; i++) q0.push_back(8'(8'hA0 + i));
            for (int i = 0; i < tbl[v].n1; i++) q1.push_back(8'(8'hB0 + i));
            j0 = 0;
            j1 = 0;
            for (int b = 0; b < tbl[v].n0 + tbl[v].n1; b++) begin
                if (tbl[v].owners[b]) begin
                    push_exp(8'(8'hB0 + j1), 1'b1);
                    j1++;
                end else begin
                    push_exp(8'(8'hA0 + j0), 1'b0);
                    j0++;
                end
            end
            enable = 1'b1;
            drain(2000);
            chk("tbl_sent0", int'(sent0), tbl[v].s0);
            chk("tbl_sent1", int'(sent1), tbl[v].s1);
            chk("tbl_left", q0.size() + q1.size(), 0);
        end

        // Random queue depths, data and uart_tx timing against the burst-level model
        rnd_uart = 1'b1;
        for (int r = 0; r < 24; r++) begin
            apply_reset();
            n0 = int'($urandom_range(0, 12));
            n1 = int'($urandom_range(0, 12));
            for (int i = 0; i < n0; i++) q0.push_back(8'($urandom_range(0, 255)));
            for (int i = 0; i < n1; i++) q1.push_back(8'($urandom_range(0, 255)));
            ref_model(n0, n1);
            enable = 1'b1;
            drain(2000);
            chk("rnd_sent0", int'(sent0), (n0 > SAT) ? SAT : n0);
            chk("rnd_sent1", int'(sent1), (n1 > SAT) ? SAT : n1);
            chk("rnd_left", q0.size() + q1.size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
